// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request per handshake, decodes Opula into
// an ALU Selection plus operand-source selects, issues it (repeating single-bit
// shifts for multi-bit shift amounts) and holds the completion until accepted.
module alu_op_sequencer #(
    parameter int unsigned SHAMT_W     = 5,
    parameter int unsigned MULTI_SHIFT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         Opula,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [4:0]         Selection,
    output logic [1:0]         SrcA_sel,
    output logic [1:0]         SrcB_sel,
    output logic               alu_en,
    output logic               acc_load,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         done_op,
    output logic               illegal,
    output logic               busy
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned SRC_W = 2;
    localparam bit          MULTI = (MULTI_SHIFT != 0);

    // Requested operation codes
    localparam logic [OP_W-1:0] OP_ADD      = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADDINC   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_INCA     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUBDEC   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB      = OP_W'(4);
    localparam logic [OP_W-1:0] OP_DECA     = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LSL      = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RSL      = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ZEROS    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_AND      = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ANDNOTA  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ANDNOTB  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_PASSA    = OP_W'(12);
    localparam logic [OP_W-1:0] OP_PASSB    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XOR      = OP_W'(14);
    localparam logic [OP_W-1:0] OP_OR       = OP_W'(15);
    localparam logic [OP_W-1:0] OP_NAND     = OP_W'(16);
    localparam logic [OP_W-1:0] OP_XNOR     = OP_W'(17);
    localparam logic [OP_W-1:0] OP_PASSNOTA = OP_W'(18);
    localparam logic [OP_W-1:0] OP_ORNOTA   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_ORNOTB   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_NOR      = OP_W'(21);
    localparam logic [OP_W-1:0] OP_ONES     = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ASR      = OP_W'(23);
    localparam logic [OP_W-1:0] OP_LAST     = OP_ASR;

    // ALU function codes
    localparam logic [SEL_W-1:0] SEL_NOT     = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_AND     = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_ANDNA   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_ANDNB   = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_NAND    = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_OR      = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_ORNA    = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_ORNB    = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_NOR     = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_XOR     = SEL_W'(9);
    localparam logic [SEL_W-1:0] SEL_XNOR    = SEL_W'(10);
    localparam logic [SEL_W-1:0] SEL_ADD     = SEL_W'(11);
    localparam logic [SEL_W-1:0] SEL_ADDINC  = SEL_W'(12);
    localparam logic [SEL_W-1:0] SEL_INCA    = SEL_W'(13);
    localparam logic [SEL_W-1:0] SEL_SUB     = SEL_W'(14);
    localparam logic [SEL_W-1:0] SEL_SUBDEC  = SEL_W'(15);
    localparam logic [SEL_W-1:0] SEL_DECA    = SEL_W'(16);
    localparam logic [SEL_W-1:0] SEL_LSL     = SEL_W'(17);
    localparam logic [SEL_W-1:0] SEL_RSL     = SEL_W'(18);
    localparam logic [SEL_W-1:0] SEL_ASR     = SEL_W'(19);

    // Operand-source selects
    localparam logic [SRC_W-1:0] SRCA_OPA  = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRCA_ZERO = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRCA_ACC  = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRCB_OPB  = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRCB_ZERO = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRCB_ONES = SRC_W'(2);

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SRC_W-1:0] srca;
        logic [SRC_W-1:0] srcb;
    } dec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Opula -> ALU function and operand sources; pseudo-ops reuse add/or with forced sources
    function automatic dec_t decode(input logic [OP_W-1:0] op);
        dec_t d;
        d.sel  = SEL_ADD;
        d.srca = SRCA_OPA;
        d.srcb = SRCB_OPB;
        case (op)
            OP_ADD:      d.sel = SEL_ADD;
            OP_ADDINC:   d.sel = SEL_ADDINC;
            OP_INCA:     d.sel = SEL_INCA;
            OP_SUBDEC:   d.sel = SEL_SUBDEC;
            OP_SUB:      d.sel = SEL_SUB;
            OP_DECA:     d.sel = SEL_DECA;
            OP_LSL:      d.sel = SEL_LSL;
            OP_RSL:      d.sel = SEL_RSL;
            OP_ZEROS: begin
                d.sel  = SEL_ADD;
                d.srca = SRCA_ZERO;
                d.srcb = SRCB_ZERO;
            end
            OP_AND:      d.sel = SEL_AND;
            OP_ANDNOTA:  d.sel = SEL_ANDNA;
            OP_ANDNOTB:  d.sel = SEL_ANDNB;
            OP_PASSA: begin
                d.sel  = SEL_ADD;
                d.srcb = SRCB_ZERO;
            end
            OP_PASSB: begin
                d.sel  = SEL_OR;
                d.srca = SRCA_ZERO;
            end
            OP_XOR:      d.sel = SEL_XOR;
            OP_OR:       d.sel = SEL_OR;
            OP_NAND:     d.sel = SEL_NAND;
            OP_XNOR:     d.sel = SEL_XNOR;
            OP_PASSNOTA: d.sel = SEL_NOT;
            OP_ORNOTA:   d.sel = SEL_ORNA;
            OP_ORNOTB:   d.sel = SEL_ORNB;
            OP_NOR:      d.sel = SEL_NOR;
            OP_ONES: begin
                d.sel  = SEL_ADD;
                d.srca = SRCA_ZERO;
                d.srcb = SRCB_ONES;
            end
            OP_ASR:      d.sel = SEL_ASR;
            default:     d.sel = SEL_ADD;
        endcase
        return d;
    endfunction

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic [SRC_W-1:0]   srca_d, srcb_d;
    logic               alu_en_d, acc_load_d, out_valid_d, illegal_d, busy_d;
    logic [OP_W-1:0]    done_op_d;

    dec_t dec_c;
    logic shift_c;

    // Decode of the captured request and shift-class detection
    always_comb begin
        dec_c   = decode(op_q);
        shift_c = (op_q == OP_LSL) || (op_q == OP_RSL) || (op_q == OP_ASR);
    end

    assign in_ready = (state_q == S_IDLE) && !reset;

    // Next-state and next-output logic; registered outputs follow the current state
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shamt_d     = shamt_q;
        cnt_d       = cnt_q;
        sel_d       = Selection;
        srca_d      = SrcA_sel;
        srcb_d      = SrcB_sel;
        alu_en_d    = 1'b0;
        acc_load_d  = 1'b0;
        out_valid_d = 1'b0;
        done_op_d   = done_op;
        illegal_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (Opula > OP_LAST) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d    = Opula;
                        shamt_d = Shamt;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_en_d   = 1'b1;
                acc_load_d = 1'b1;
                sel_d      = dec_c.sel;
                srca_d     = dec_c.srca;
                srcb_d     = dec_c.srcb;
                cnt_d      = '0;
                state_d    = S_DONE;
                if (shift_c && MULTI) begin
                    if (shamt_q == '0) begin
                        // zero-length shift degenerates to pass A
                        sel_d  = SEL_ADD;
                        srca_d = SRCA_OPA;
                        srcb_d = SRCB_ZERO;
                    end else if (shamt_q > SHAMT_W'(1)) begin
                        cnt_d   = shamt_q - SHAMT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // further single-bit shifts operate on the accumulated result
                alu_en_d   = 1'b1;
                acc_load_d = 1'b1;
                sel_d      = dec_c.sel;
                srca_d     = SRCA_ACC;
                srcb_d     = SRCB_OPB;
                if (cnt_q == SHAMT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - SHAMT_W'(1);
                end
            end
            S_DONE: begin
                done_op_d = op_q;
                if (out_valid && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, captured request and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            shamt_q   <= '0;
            cnt_q     <= '0;
            Selection <= '0;
            SrcA_sel  <= '0;
            SrcB_sel  <= '0;
            alu_en    <= 1'b0;
            acc_load  <= 1'b0;
            out_valid <= 1'b0;
            done_op   <= '0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            shamt_q   <= shamt_d;
            cnt_q     <= cnt_d;
            Selection <= sel_d;
            SrcA_sel  <= srca_d;
            SrcB_sel  <= srcb_d;
            alu_en    <= alu_en_d;
            acc_load  <= acc_load_d;
            out_valid <= out_valid_d;
            done_op   <= done_op_d;
            illegal   <= illegal_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (multi-shift on / off), queued
// expectations from a reference model, and a negedge monitor that checks them.
module tb_alu_op_sequencer;

    typedef struct {
        logic [4:0] op;
        bit         ill;
        int         n;
        logic [4:0] sel;
        logic [4:0] shsel;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] in_valid, in_ready, alu_en, acc_load, out_valid, out_ready, illegal, busy;
    logic [4:0] opula [2];
    logic [4:0] shamt [2];
    logic [4:0] sel [2];
    logic [4:0] done_op [2];
    logic [1:0] srca [2];
    logic [1:0] srcb [2];

    int n_vec = 0;
    int n_err = 0;

    // Selection for each legal Opula 0..23
    int sel_tab [24] = '{11, 12, 13, 15, 14, 16, 17, 18, 11, 1, 2, 3,
                         11, 5, 9, 5, 4, 10, 0, 6, 7, 8, 11, 19};

    exp_t q0 [$];
    exp_t q1 [$];
    bit   mon_act [2];
    bit   mon_seen [2];
    bit   mon_post [2];
    int   mon_age [2];
    int   mon_iss [2];
    exp_t mon_cur [2];
    bit   ordy_hold [2];

    always #5 clock = ~clock;

    alu_op_sequencer #(.SHAMT_W(5), .MULTI_SHIFT(1)) u_multi (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Opula(opula[0]), .Shamt(shamt[0]), .Selection(sel[0]), .SrcA_sel(srca[0]),
        .SrcB_sel(srcb[0]), .alu_en(alu_en[0]), .acc_load(acc_load[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .done_op(done_op[0]),
        .illegal(illegal[0]), .busy(busy[0]));

    alu_op_sequencer #(.SHAMT_W(5), .MULTI_SHIFT(0)) u_single (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Opula(opula[1]), .Shamt(shamt[1]), .Selection(sel[1]), .SrcA_sel(srca[1]),
        .SrcB_sel(srcb[1]), .alu_en(alu_en[1]), .acc_load(acc_load[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .done_op(done_op[1]),
        .illegal(illegal[1]), .busy(busy[1]));

    function automatic void chk(input string name, input bit ok, input string det);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, det);
        end
    endfunction

    // Reference: what a request must produce, from the opcode tables and shift rules
    function automatic exp_t model(input bit multi, input logic [4:0] op, input int sh);
        exp_t e;
        bit   shf;
        e.op = op; e.ill = (op > 5'd23); e.n = 0; e.sel = '0; e.shsel = '0; e.a = '0; e.b = '0;
        if (!e.ill) begin
            e.n     = 1;
            e.sel   = 5'(sel_tab[int'(op)]);
            e.shsel = e.sel;
            if (op == 5'd8)  begin e.a = 2'd1; e.b = 2'd1; end
            if (op == 5'd12) e.b = 2'd1;
            if (op == 5'd13) e.a = 2'd1;
            if (op == 5'd22) begin e.a = 2'd1; e.b = 2'd2; end
            shf = (op == 5'd6) || (op == 5'd7) || (op == 5'd23);
            if (shf && multi) begin
                if (sh == 0) begin e.sel = 5'd11; e.b = 2'd1; end
                else e.n = sh;
            end
        end
        return e;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit all_zero(input int g);
        return sel[g] == 0 && srca[g] == 0 && srcb[g] == 0 && alu_en[g] == 0 && acc_load[g] == 0 &&
               out_valid[g] == 0 && done_op[g] == 0 && illegal[g] == 0 && busy[g] == 0;
    endfunction

    // Issue one request; called at posedge+1, returns just after the accepting edge
    task automatic drive(input int d, input logic [4:0] op, input int sh);
        bit acc;
        exp_t e;
        e = model(d == 0, op, sh);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        in_valid[d] = 1'b1;
        opula[d]    = op;
        shamt[d]    = 5'(sh);
        acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clock);
            acc = in_ready[d];
            @(posedge clock);
            #1;
        end
        if (!acc) begin
            chk("accept_timeout", 1'b0, $sformatf("dut%0d op %0d never accepted", d, op));
            if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end
        in_valid[d] = 1'b0;
        opula[d]    = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            if (!mon_act[d] && qsize(d) == 0) ok = 1'b1;
            else begin @(posedge clock); #1; end
        end
        if (!ok) begin
            chk("idle_timeout", 1'b0, $sformatf("dut%0d still busy, act=%0d q=%0d", d, mon_act[d], qsize(d)));
            mon_act[d] = 1'b0;
        end
    endtask

    // Consumer readiness: random unless held off for a directed test
    always @(posedge clock) begin
        #2;
        for (int d = 0; d < 2; d++)
            out_ready[d] = ordy_hold[d] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the expected response at acceptance and checks every issue and completion
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                mon_act[g]  = 1'b0;
                mon_post[g] = 1'b0;
            end else begin
                if (mon_post[g]) begin
                    mon_post[g] = 1'b0;
                    chk("release", out_valid[g] == 0 && in_ready[g] == 1 && busy[g] == 0,
                        $sformatf("dut%0d out_valid=%0d in_ready=%0d busy=%0d, need 0/1/0",
                                  g, out_valid[g], in_ready[g], busy[g]));
                end
                if (mon_act[g]) begin
                    mon_age[g]++;
                    if (mon_cur[g].ill) begin
                        chk("illegal", illegal[g] == 1 && alu_en[g] == 0 && in_ready[g] == 1 && busy[g] == 0,
                            $sformatf("dut%0d op %0d illegal=%0d alu_en=%0d in_ready=%0d busy=%0d, need 1/0/1/0",
                                      g, mon_cur[g].op, illegal[g], alu_en[g], in_ready[g], busy[g]));
                        mon_act[g] = 1'b0;
                    end else begin
                        if (alu_en[g]) begin
                            logic [4:0] es;
                            logic [1:0] ea, eb;
                            mon_iss[g]++;
                            es = (mon_iss[g] == 1) ? mon_cur[g].sel : mon_cur[g].shsel;
                            ea = (mon_iss[g] == 1) ? mon_cur[g].a : 2'd2;
                            eb = (mon_iss[g] == 1) ? mon_cur[g].b : 2'd0;
                            chk("issue", sel[g] == es && srca[g] == ea && srcb[g] == eb && acc_load[g] == 1 &&
                                busy[g] == 1 && mon_age[g] == mon_iss[g] + 1 && mon_iss[g] <= mon_cur[g].n,
                                $sformatf("dut%0d op %0d issue %0d age %0d: sel=%0d a=%0d b=%0d ld=%0d, need sel=%0d a=%0d b=%0d ld=1 age=%0d max %0d",
                                          g, mon_cur[g].op, mon_iss[g], mon_age[g], sel[g], srca[g], srcb[g],
                                          acc_load[g], es, ea, eb, mon_iss[g] + 1, mon_cur[g].n));
                        end
                        if (out_valid[g]) begin
                            chk("done", done_op[g] == mon_cur[g].op && mon_iss[g] == mon_cur[g].n && alu_en[g] == 0 &&
                                busy[g] == 1 && in_ready[g] == 0 && (mon_seen[g] || mon_age[g] == mon_cur[g].n + 2),
                                $sformatf("dut%0d done_op=%0d issues=%0d age=%0d alu_en=%0d in_ready=%0d, need op=%0d issues=%0d age=%0d",
                                          g, done_op[g], mon_iss[g], mon_age[g], alu_en[g], in_ready[g],
                                          mon_cur[g].op, mon_cur[g].n, mon_cur[g].n + 2));
                            mon_seen[g] = 1'b1;
                            if (out_ready[g]) begin
                                mon_act[g]  = 1'b0;
                                mon_post[g] = 1'b1;
                            end
                        end else if (mon_seen[g]) begin
                            chk("hold", 1'b0, $sformatf("dut%0d out_valid dropped before out_ready", g));
                            mon_act[g] = 1'b0;
                        end
                        if (mon_act[g] && mon_age[g] > 80) begin
                            chk("done_timeout", 1'b0, $sformatf("dut%0d op %0d no completion by age %0d",
                                                                 g, mon_cur[g].op, mon_age[g]));
                            mon_act[g] = 1'b0;
                        end
                    end
                end else if (alu_en[g] || out_valid[g] || illegal[g]) begin
                    chk("spurious", 1'b0, $sformatf("dut%0d alu_en=%0d out_valid=%0d illegal=%0d with nothing in flight",
                                                     g, alu_en[g], out_valid[g], illegal[g]));
                end
                if (in_valid[g] && in_ready[g]) begin
                    if (qsize(g) == 0) begin
                        chk("sb_empty", 1'b0, $sformatf("dut%0d accepted with no expectation", g));
                    end else begin
                        mon_cur[g]  = (g == 0) ? q0.pop_front() : q1.pop_front();
                        mon_act[g]  = 1'b1;
                        mon_seen[g] = 1'b0;
                        mon_age[g]  = 0;
                        mon_iss[g]  = 0;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = '0; out_ready = '0;
        for (int d = 0; d < 2; d++) begin
            opula[d] = '0; shamt[d] = '0; ordy_hold[d] = 1'b0;
            mon_act[d] = 1'b0; mon_post[d] = 1'b0; mon_seen[d] = 1'b0;
            mon_age[d] = 0; mon_iss[d] = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++)
            chk("reset_state", all_zero(d) && in_ready[d] == 0,
                $sformatf("dut%0d outputs not cleared or in_ready=%0d during reset", d, in_ready[d]));
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++)
            chk("reset_release", in_ready[d] == 1 && all_zero(d),
                $sformatf("dut%0d in_ready=%0d after reset, need 1", d, in_ready[d]));
        @(posedge clock); #1;

        // Directed cases, multi-shift instance
        drive(0, 5'd9, 3);  wait_idle(0);
        drive(0, 5'd6, 4);  wait_idle(0);
        drive(0, 5'd23, 0); wait_idle(0);
        drive(0, 5'd22, 0); wait_idle(0);
        drive(0, 5'd12, 0); wait_idle(0);
        drive(0, 5'd13, 0); wait_idle(0);
        drive(0, 5'd24, 0);
        drive(0, 5'd1, 5);  wait_idle(0);
        drive(0, 5'd31, 0); wait_idle(0);
        drive(0, 5'd7, 1);  wait_idle(0);
        drive(0, 5'd7, 31); wait_idle(0);

        // Directed cases, single-shift instance
        drive(1, 5'd6, 4);  wait_idle(1);
        drive(1, 5'd7, 9);  wait_idle(1);
        drive(1, 5'd23, 0); wait_idle(1);
        drive(1, 5'd18, 2); wait_idle(1);

        // Completion held by the consumer; a new request must wait
        ordy_hold[0] = 1'b1;
        drive(0, 5'd8, 0);
        fork
            begin
                repeat (5) @(negedge clock);
                chk("hold_stable", out_valid[0] == 1 && done_op[0] == 5'd8 && in_ready[0] == 0,
                    $sformatf("out_valid=%0d done_op=%0d in_ready=%0d, need 1/8/0",
                              out_valid[0], done_op[0], in_ready[0]));
                ordy_hold[0] = 1'b0;
            end
            drive(0, 5'd15, 0);
        join
        wait_idle(0);

        // Reset in the middle of a multi-cycle shift
        drive(0, 5'd7, 9);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mid_reset1", all_zero(0) && in_ready[0] == 0, "outputs not cleared in reset cycle 1");
        @(posedge clock);
        @(negedge clock);
        chk("mid_reset2", all_zero(0) && in_ready[0] == 0, "outputs not cleared in reset cycle 2");
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("mid_reset_rel", all_zero(0) && in_ready[0] == 1,
            $sformatf("after release in_ready=%0d out_valid=%0d, need 1/0", in_ready[0], out_valid[0]));
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            chk("aborted_op", out_valid[0] == 0 && alu_en[0] == 0,
                $sformatf("out_valid=%0d alu_en=%0d after abort, need 0/0", out_valid[0], alu_en[0]));
        end
        @(posedge clock); #1;

        // Randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            int sh;
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            drive(0, 5'($urandom_range(0, 27)), sh);
            if ($urandom_range(0, 1) == 0) wait_idle(0);
        end
        wait_idle(0);
        for (int i = 0; i < 50; i++) begin
            drive(1, 5'($urandom_range(0, 27)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 0) wait_idle(1);
        end
        wait_idle(1);
        repeat (4) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
